// File: rtl/ayatsuki_inst_mem.sv
// Byte-addressed instruction memory with one outstanding 32-bit fetch.
// Latency: accept edge to rvalid_o is WAIT_CYCLES+1 cycles, counted from the request cycle.
// Backpressure: ready_o low only while a fetch is waiting; flush_i aborts a waiting fetch.
module ayatsuki_inst_mem #(
  parameter int ADDR_W      = 11,
  parameter int DEPTH       = 2048,
  parameter int WAIT_CYCLES = 1,
  parameter int BIG_ENDIAN  = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              ready_o,
  input  logic              flush_i,
  output logic              rvalid_o,
  output logic [31:0]       inst_o,
  output logic              err_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       inst_q, inst_d;
  logic              err_q, err_d;

  logic              accept;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rd_end;
  logic              rd_err;
  logic [7:0]        rd_b0, rd_b1, rd_b2, rd_b3;
  logic [31:0]       rd_inst;

  assign ready_o  = (state_q != S_WAIT);
  assign rvalid_o = (state_q == S_RESP);
  assign inst_o   = inst_q;
  assign err_o    = err_q;
  assign accept   = req_i & ready_o;

  // Assemble the word that would be captured on this edge: a waiting fetch uses its
  // latched address, a zero-wait accept reads straight from addr_i.
  always_comb begin
    rd_addr = (state_q == S_WAIT) ? addr_q : addr_i;
    rd_end  = {1'b0, rd_addr} + (ADDR_W+1)'(3);
    rd_err  = (rd_end >= DEPTH_L) || ((ALIGN_CHECK != 0) && (rd_addr[1:0] != 2'b00));
    rd_b0   = mem_q[rd_addr];
    rd_b1   = mem_q[rd_addr + ADDR_W'(1)];
    rd_b2   = mem_q[rd_addr + ADDR_W'(2)];
    rd_b3   = mem_q[rd_addr + ADDR_W'(3)];
    if (rd_err) begin
      rd_inst = 32'h0;
    end else if (BIG_ENDIAN != 0) begin
      rd_inst = {rd_b0, rd_b1, rd_b2, rd_b3};
    end else begin
      rd_inst = {rd_b3, rd_b2, rd_b1, rd_b0};
    end
  end

  // Next-state logic: accept, wait countdown, abort on flush, capture on RESP entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          addr_d = addr_i;
          cnt_d  = WAIT_L;
          if (WAIT_L == 4'd0) begin
            state_d = S_RESP;
            inst_d  = rd_inst;
            err_d   = rd_err;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
          inst_d  = rd_inst;
          err_d   = rd_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control and response registers; a reset discards any pending fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      inst_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  // Byte array: contents survive reset, writes are blocked while reset is held,
  // and out-of-range write addresses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && wr_en_i && ({1'b0, wr_addr_i} < DEPTH_L)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

endmodule
